inv_mix_columns_iter: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the forward MixColumns stage. It accepts one 128-bit state through a valid/ready handshake and processes one 32-bit column per clock over 4 cycles. It then holds the result under a valid/ready output handshake. It sits between InvShiftRows/InvSubBytes/AddRoundKey in the decrypt round loop.

---
 rtl/inv_mix_columns_iter.sv | 107 ++++++++++
 tb/tb_inv_mix_columns_iter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// Purpose: iterative AES InvMixColumns, one 32-bit column per cycle over a 128-bit state.
// Latency: accept at edge N, columns written at N+1..N+4, out_valid from N+4; 6 cycles/block minimum.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready is seen.
module inv_mix_columns_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [1:0]   col;
    logic [0:127] state_reg;
    logic [0:127] res_reg;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column of InvMixColumns built from xtime chains; byte 0 sits in c[31:24].
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [3:0][7:0] a;
        logic [3:0][7:0] x2;
        logic [3:0][7:0] x4;
        logic [3:0][7:0] x8;
        logic [3:0][7:0] r;
        logic [1:0]      k;
        a = {c[7:0], c[15:8], c[23:16], c[31:24]};
        for (int i = 0; i < 4; i++) begin
            k     = 2'(i);
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
        end
        for (int i = 0; i < 4; i++) begin
            k    = 2'(i);
            // 0e*a_r ^ 0b*a_r+1 ^ 0d*a_r+2 ^ 09*a_r+3, indices wrap via 2-bit k
            r[k] = (x8[k] ^ x4[k] ^ x2[k])
                 ^ (x8[k + 2'd1] ^ x2[k + 2'd1] ^ a[k + 2'd1])
                 ^ (x8[k + 2'd2] ^ x4[k + 2'd2] ^ a[k + 2'd2])
                 ^ (x8[k + 2'd3] ^ a[k + 2'd3]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // Select the column currently being processed and transform it.
    always_comb begin
        col_in  = state_reg[{col, 5'd0} +: 32];
        col_out = inv_col(col_in);
    end

    // Handshake and status outputs decode straight from the state register.
    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out       = res_reg;

    // Control FSM plus state/result registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            col       <= 2'd0;
            state_reg <= '0;
            res_reg   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in;
                        col       <= 2'd0;
                        fsm       <= CALC;
                    end
                end
                CALC: begin
                    res_reg[{col, 5'd0} +: 32] <= col_out;
                    col                        <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: known vectors, reset, stall, back-to-back and random round-trip.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Reference model is a generic GF(2^8) matrix multiply over the 4x4 column matrix.
module tb_inv_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_d = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_d;
    logic         busy;

    int passed = 0;
    int total  = 0;

    inv_mix_columns_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_d),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Carry-less product then polynomial reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--)
            if (p[i]) p ^= 15'(9'h11b) << (i - 8);
        return p[7:0];
    endfunction

    // Circulant column transform: out_r = k0*a_r ^ k1*a_r+1 ^ k2*a_r+2 ^ k3*a_r+3.
    function automatic logic [127:0] col_xform(input logic [127:0] x, input logic [7:0] k0,
                                               input logic [7:0] k1, input logic [7:0] k2,
                                               input logic [7:0] k3);
        logic [7:0]   a [4];
        logic [7:0]   kk [4];
        logic [7:0]   b;
        logic [127:0] r;
        kk[0] = k0; kk[1] = k1; kk[2] = k2; kk[3] = k3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = x[127 - 8 * (4 * c + j) -: 8];
            for (int row = 0; row < 4; row++) begin
                b = '0;
                for (int j = 0; j < 4; j++) b ^= gmul(kk[j], a[(row + j) % 4]);
                r[127 - 8 * (4 * c + row) -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] x);
        return col_xform(x, 8'h02, 8'h03, 8'h01, 8'h01);
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] x);
        return col_xform(x, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer d, wait for accept, wait for out_valid, capture and complete the handshake.
    task automatic run_block(input logic [127:0] d, output logic [127:0] res, output int lat);
        int n;
        n = 0;
        in_d = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_d = rnd128();
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        res = out_d;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    initial begin
        vec_t         vecs [4];
        logic [127:0] res;
        logic [127:0] x;
        logic [127:0] snap;
        logic [127:0] b2b_in [3];
        logic [127:0] b2b_out [3];
        int           b2b_t [3];
        int           lat;
        int           err;
        int           got;
        int           k;
        logic         acc;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
        vecs[2] = '{{128{1'b1}}, {128{1'b1}}};
        vecs[3] = '{128'h0, 128'h0};

        // Reset state while held in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
        chk("reset_out", out_d, 128'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known vectors with latency check.
        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].din, res, lat);
            chk($sformatf("vec%0d_out", i), res, vecs[i].dexp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd4);
        end

        // Reset in the middle of CALC.
        in_d = vecs[1].din;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midcalc_reset_flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
        chk("midcalc_reset_out", out_d, 128'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_block(vecs[0].din, res, lat);
        chk("post_reset_out", res, vecs[0].dexp);
        chk("post_reset_latency", 128'(lat), 128'd4);

        // Back-pressure: 20-cycle stall with a stray in_valid pulse.
        x = rnd128();
        in_d = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("stall_latency", 128'(lat), 128'd4);
        snap = out_d;
        err = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin in_valid = 1'b1; in_d = rnd128(); end
            if (c == 11) in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_d !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) err++;
        end
        chk("stall_stability_errors", 128'(err), 128'd0);
        chk("stall_out", out_d, inv_mix(x));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("stall_pulse_ignored", {125'd0, in_ready, out_valid, busy}, 128'b100);
        chk("out_held_in_idle", out_d, inv_mix(x));

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 3; i++) b2b_in[i] = rnd128();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_d = b2b_in[0];
        k = 0;
        got = 0;
        err = 0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            if (out_valid) begin
                b2b_out[got] = out_d;
                b2b_t[got] = cyc;
                got++;
            end
            if (in_ready === busy) err++;
            acc = in_ready;
            @(posedge clk); #1;
            if (acc && k < 3) begin
                k++;
                if (k < 3) in_d = b2b_in[k];
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_count", 128'(got), 128'd3);
        chk("b2b_ready_only_idle", 128'(err), 128'd0);
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_out%0d", i), b2b_out[i], inv_mix(b2b_in[i]));
        chk("b2b_period01", 128'(b2b_t[1] - b2b_t[0]), 128'd6);
        chk("b2b_period12", 128'(b2b_t[2] - b2b_t[1]), 128'd6);

        // Random round-trip through forward MixColumns.
        for (int i = 0; i < 1000; i++) begin
            x = rnd128();
            if (i % 50 == 0) x[127:120] = 8'h00;
            if (i % 50 == 1) x[95:88] = 8'h80;
            run_block(mix(x), res, lat);
            chk($sformatf("roundtrip%0d", i), res, x);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
